dmac_req_arbiter: RTL and testbench
===================================

// Module: dmac_req_arbiter
// PURPOSE
//  Arbitrates NUM_REQ peripheral DMA requests and runs each bus tenure for the DMAC.
//  It picks one requester (fixed or round-robin priority) and requests the AHB bus.
//  Once the bus is granted and the channel is configured, it enables the matching channel,
//  holds the bus until that channel reports done, then releases the bus and interrupts.
//  Sits between the peripheral DmacReq lines, the AHB arbiter and the channel datapaths.
// PARAMETERS
//  NUM_REQ        2    number of requesters/channels (>=2)
//  RR_EN          0    0: fixed priority, highest index wins; 1: round-robin
//  GRANT_TIMEOUT  255  max cycles waiting in REQ_BUS; 0 disables the timeout
//  CHW            $clog2(NUM_REQ)  channel index width (derived, do not override)
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous, active-high reset
//  dmac_req       in   NUM_REQ  level requests from peripherals
//  bus_grant      in   1        AHB arbiter grant to DMAC master
//  cfg_valid      in   1        selected channel's config registers are loaded
//  chan_done      in   1        selected channel finished its transfer (level or pulse)
//  bus_req        out  1        bus request to AHB arbiter
//  hold           out  1        keep slave interface locked/busy
//  chan_en        out  NUM_REQ  one-hot, one-cycle channel start pulse
//  req_ack        out  NUM_REQ  one-hot, one-cycle acknowledge to peripheral
//  active_ch      out  CHW      index of channel owning the tenure
//  busy           out  1        state != IDLE
//  interrupt      out  1        one-cycle end-of-transfer pulse
//  grant_timeout  out  1        one-cycle pulse when grant wait expires
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is synchronous, active-high.
//  - Reset: state=IDLE; rr_ptr=0; sel_q=0; timeout counter=0; all outputs 0.
//  - Outputs are decoded from registered state/sel_q only (Moore), so they never glitch.
//  - IDLE: if |dmac_req, latch the winner in sel_q and go to REQ_BUS; otherwise stay.
//      Fixed priority: highest set index wins.
//      Round-robin: first set index at or after rr_ptr, wrapping modulo NUM_REQ.
//  - REQ_BUS: bus_req=1, hold=1, counter increments each cycle.
//      bus_grant && cfg_valid -> ENABLE; counter cleared.
//      dmac_req[sel_q] falls first -> IDLE; no ack, no interrupt.
//      Counter==GRANT_TIMEOUT-1 (GRANT_TIMEOUT!=0) -> TIMEOUT.
//      Precedence when events coincide: grant > withdraw > timeout.
//  - ENABLE (exactly 1 cycle): chan_en[sel_q]=1, req_ack[sel_q]=1, bus_req=1, hold=1 -> XFER.
//  - XFER: bus_req=1, hold=1. Wait for chan_done, then go to DONE.
//      chan_done is sampled only in XFER; in any other state it is ignored.
//      New requests are ignored. Loss of bus_grant does not abort; bus_req stays high.
//  - DONE (1 cycle): interrupt=1, bus_req=0, hold=0.
//      If RR_EN, rr_ptr=(sel_q+1) mod NUM_REQ (wraps NUM_REQ-1 -> 0). Then -> IDLE.
//  - TIMEOUT (1 cycle): grant_timeout=1, bus_req=0.
//      rr_ptr advances as in DONE, so a starved requester cannot lock out the others. Then -> IDLE.
//  - Minimum tenure: IDLE->REQ_BUS->ENABLE->XFER->DONE->IDLE = 5 cycles with immediate grant/done.
//  - Back-to-back: the earliest re-arbitration is the IDLE cycle after DONE (no IDLE skipping).
//  - active_ch=sel_q in every state except IDLE, where it is 0.
//  - rst asserted mid-tenure: next edge returns all state and outputs to reset values.
//      No interrupt and no ack is generated; the channel datapath is reset by the same rst.
// STRUCTURE
//  - dmac_pkg: arb_state_t enum {IDLE,REQ_BUS,ENABLE,XFER,DONE,TIMEOUT}, localparams ARB_FIXED=0, ARB_RR=1.
//  - Sub-module dmac_rr_picker: combinational.
//      Inputs: req vector, rr_ptr, RR_EN. Outputs: winner index and any_req.
//  - This block keeps only the FSM, sel_q, rr_ptr and the timeout counter.
// TESTING
//  1. NUM_REQ=2 fixed, req=2'b11, grant and cfg_valid tied 1
//       -> chan_en=2'b10 and req_ack=2'b10 in cycle 3; after chan_done, interrupt pulses once.
//  2. RR_EN=1, req=2'b11 held for 3 tenures
//       -> served order 0,1,0; rr_ptr wraps 1->0.
//  3. grant held 0, GRANT_TIMEOUT=8
//       -> grant_timeout pulses 9 cycles after leaving IDLE; bus_req drops that cycle; no chan_en.
//  4. req[1] dropped in REQ_BUS before grant
//       -> IDLE next cycle; no req_ack, no interrupt; req[0] is served afterwards.
//  5. rst asserted during XFER
//       -> next cycle bus_req=hold=busy=0 and state=IDLE; no interrupt pulse.
//  6. grant and timeout on the same cycle -> ENABLE is taken; grant_timeout stays 0.

Source files
------------

// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMAC request arbiter.
package dmac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_BUS,
    ENABLE,
    XFER,
    DONE,
    TIMEOUT
  } arb_state_t;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

endpackage

// File: rtl/dmac_rr_picker.sv
// Combinational winner select: highest index (fixed) or first at/after rr_ptr (round-robin).
module dmac_rr_picker
  import dmac_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  parameter  int unsigned RR_EN   = ARB_FIXED,
  localparam int unsigned CHW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [CHW-1:0]     i_rr_ptr,
  output logic [CHW-1:0]     o_winner,
  output logic               o_any_req
);

  logic [31:0] w_idx;
  logic        w_found;

  always_comb begin
    o_winner  = '0;
    o_any_req = |i_req;
    w_idx     = '0;
    w_found   = 1'b0;
    if (RR_EN != ARB_FIXED) begin
      // Scan from rr_ptr upwards, wrapping; the first hit wins.
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_idx = 32'(i_rr_ptr) + 32'(k);
        if (w_idx >= NUM_REQ) begin
          w_idx = w_idx - NUM_REQ;
        end
        if (!w_found && i_req[w_idx[CHW-1:0]]) begin
          o_winner = w_idx[CHW-1:0];
          w_found  = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_idx = 32'(k);
        if (i_req[w_idx[CHW-1:0]]) begin
          o_winner = w_idx[CHW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/dmac_req_arbiter.sv
// DMA request arbiter: picks a requester, owns the AHB tenure, starts its channel, signals done.
module dmac_req_arbiter
  import dmac_pkg::*;
#(
  parameter  int unsigned NUM_REQ       = 2,
  parameter  int unsigned RR_EN         = ARB_FIXED,
  parameter  int unsigned GRANT_TIMEOUT = 255,
  localparam int unsigned CHW           = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_dmac_req,
  input  logic               i_bus_grant,
  input  logic               i_cfg_valid,
  input  logic               i_chan_done,
  output logic               o_bus_req,
  output logic               o_hold,
  output logic [NUM_REQ-1:0] o_chan_en,
  output logic [NUM_REQ-1:0] o_req_ack,
  output logic [CHW-1:0]     o_active_ch,
  output logic               o_busy,
  output logic               o_interrupt,
  output logic               o_grant_timeout
);

  localparam int unsigned CntW = (GRANT_TIMEOUT > 2) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast =
      (GRANT_TIMEOUT == 0) ? '0 : CntW'(GRANT_TIMEOUT - 1);

  arb_state_t     r_state, w_state_nxt;
  logic [CHW-1:0] r_sel, w_sel_nxt;
  logic [CHW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;

  logic [CHW-1:0]     w_winner;
  logic               w_any_req;
  logic [CHW-1:0]     w_ptr_adv;
  logic [NUM_REQ-1:0] w_sel_onehot;

  dmac_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .RR_EN   (RR_EN)
  ) u_picker (
    .i_req     (i_dmac_req),
    .i_rr_ptr  (r_rr_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  assign w_ptr_adv    = (r_sel == CHW'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;
  assign w_sel_onehot = NUM_REQ'(1) << r_sel;

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_rr_ptr_nxt = r_rr_ptr;
    w_cnt_nxt    = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_sel_nxt   = w_winner;
          w_state_nxt = REQ_BUS;
        end
      end
      REQ_BUS: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // Grant beats withdraw, withdraw beats timeout.
        if (i_bus_grant && i_cfg_valid) begin
          w_state_nxt = ENABLE;
          w_cnt_nxt   = '0;
        end else if (!i_dmac_req[r_sel]) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if ((GRANT_TIMEOUT != 0) && (r_cnt == CntLast)) begin
          w_state_nxt = TIMEOUT;
          w_cnt_nxt   = '0;
        end
      end
      ENABLE: w_state_nxt = XFER;
      XFER: begin
        if (i_chan_done) begin
          w_state_nxt = DONE;
        end
      end
      DONE, TIMEOUT: begin
        w_state_nxt = IDLE;
        if (RR_EN != ARB_FIXED) begin
          w_rr_ptr_nxt = w_ptr_adv;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_bus_req       = 1'b0;
    o_hold          = 1'b0;
    o_chan_en       = '0;
    o_req_ack       = '0;
    o_interrupt     = 1'b0;
    o_grant_timeout = 1'b0;
    o_busy          = (r_state != IDLE);
    o_active_ch     = (r_state == IDLE) ? '0 : r_sel;
    unique case (r_state)
      REQ_BUS, XFER: begin
        o_bus_req = 1'b1;
        o_hold    = 1'b1;
      end
      ENABLE: begin
        o_bus_req = 1'b1;
        o_hold    = 1'b1;
        o_chan_en = w_sel_onehot;
        o_req_ack = w_sel_onehot;
      end
      DONE:    o_interrupt     = 1'b1;
      TIMEOUT: o_grant_timeout = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_dmac_req_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter driven by hand-computed steps.
module tb_dmac_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] f_req, r_req;
  logic       f_grant, f_cfg, f_done;
  logic       r_grant, r_cfg, r_done;

  logic       f_bus_req, f_hold, f_busy, f_irq, f_gto, f_ach;
  logic [1:0] f_chan_en, f_req_ack;
  logic       r_bus_req, r_hold, r_busy, r_irq, r_gto, r_ach;
  logic [1:0] r_chan_en, r_req_ack;

  int n_checks = 0;
  int n_errors = 0;

  dmac_req_arbiter #(
    .NUM_REQ       (2),
    .RR_EN         (0),
    .GRANT_TIMEOUT (8)
  ) dut_f (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_dmac_req      (f_req),
    .i_bus_grant     (f_grant),
    .i_cfg_valid     (f_cfg),
    .i_chan_done     (f_done),
    .o_bus_req       (f_bus_req),
    .o_hold          (f_hold),
    .o_chan_en       (f_chan_en),
    .o_req_ack       (f_req_ack),
    .o_active_ch     (f_ach),
    .o_busy          (f_busy),
    .o_interrupt     (f_irq),
    .o_grant_timeout (f_gto)
  );

  dmac_req_arbiter #(
    .NUM_REQ       (2),
    .RR_EN         (1),
    .GRANT_TIMEOUT (8)
  ) dut_r (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_dmac_req      (r_req),
    .i_bus_grant     (r_grant),
    .i_cfg_valid     (r_cfg),
    .i_chan_done     (r_done),
    .o_bus_req       (r_bus_req),
    .o_hold          (r_hold),
    .o_chan_en       (r_chan_en),
    .o_req_ack       (r_req_ack),
    .o_active_ch     (r_ach),
    .o_busy          (r_busy),
    .o_interrupt     (r_irq),
    .o_grant_timeout (r_gto)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed as {bus_req, hold, busy, chan_en[1:0], req_ack[1:0], active_ch, interrupt, timeout}.
  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic exp_f(input string tag, input logic br, input logic hd, input logic bz,
                       input logic [1:0] en, input logic [1:0] ak, input logic ach,
                       input logic irq, input logic gto);
    chk(tag, {f_bus_req, f_hold, f_busy, f_chan_en, f_req_ack, f_ach, f_irq, f_gto},
        {br, hd, bz, en, ak, ach, irq, gto});
  endtask

  task automatic exp_r(input string tag, input logic br, input logic hd, input logic bz,
                       input logic [1:0] en, input logic [1:0] ak, input logic ach,
                       input logic irq, input logic gto);
    chk(tag, {r_bus_req, r_hold, r_busy, r_chan_en, r_req_ack, r_ach, r_irq, r_gto},
        {br, hd, bz, en, ak, ach, irq, gto});
  endtask

  initial begin
    rst = 1'b1;
    f_req = '0; f_grant = 1'b0; f_cfg = 1'b0; f_done = 1'b0;
    r_req = '0; r_grant = 1'b0; r_cfg = 1'b0; r_done = 1'b0;
    tick();
    tick();
    exp_f("reset_f", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    exp_r("reset_r", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    rst = 1'b0;

    // Fixed priority: both requesting, highest index wins; start pulse in cycle 3.
    f_req = 2'b11; f_grant = 1'b1; f_cfg = 1'b1;
    tick(); exp_f("t1_req_bus", 1, 1, 1, 2'b00, 2'b00, 1, 0, 0);
    tick(); exp_f("t1_enable", 1, 1, 1, 2'b10, 2'b10, 1, 0, 0);
    f_grant = 1'b0; f_req = 2'b01;
    tick(); exp_f("t1_xfer", 1, 1, 1, 2'b00, 2'b00, 1, 0, 0);
    tick(); exp_f("t1_xfer_no_abort", 1, 1, 1, 2'b00, 2'b00, 1, 0, 0);
    f_done = 1'b1; f_req = 2'b00;
    tick(); exp_f("t1_done", 0, 0, 1, 2'b00, 2'b00, 1, 1, 0);
    f_done = 1'b0;
    tick(); exp_f("t1_idle", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // Withdraw of req[1] before grant, then req[0] is served.
    f_req = 2'b11; f_grant = 1'b0;
    tick(); exp_f("t4_req_bus", 1, 1, 1, 2'b00, 2'b00, 1, 0, 0);
    f_req = 2'b01;
    tick(); exp_f("t4_withdraw", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    f_grant = 1'b1;
    tick(); exp_f("t4_req_bus0", 1, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    tick(); exp_f("t4_enable0", 1, 1, 1, 2'b01, 2'b01, 0, 0, 0);
    f_req = 2'b00; f_done = 1'b1;
    tick(); exp_f("t4_xfer", 1, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    tick(); exp_f("t4_done", 0, 0, 1, 2'b00, 2'b00, 0, 1, 0);
    f_done = 1'b0;
    tick(); exp_f("t4_idle", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // Grant never comes: timeout pulse on the 9th cycle after leaving IDLE.
    f_req = 2'b01; f_grant = 1'b0;
    tick(); exp_f("t3_req_bus", 1, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      tick(); exp_f("t3_wait", 1, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    end
    tick(); exp_f("t3_timeout", 0, 0, 1, 2'b00, 2'b00, 0, 0, 1);
    f_req = 2'b00;
    tick(); exp_f("t3_idle", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // Grant on the same cycle the timeout would fire; done held high outside XFER.
    f_req = 2'b01; f_grant = 1'b0; f_done = 1'b1;
    tick(); exp_f("t6_req_bus", 1, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      tick(); exp_f("t6_wait", 1, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    end
    f_grant = 1'b1;
    tick(); exp_f("t6_enable", 1, 1, 1, 2'b01, 2'b01, 0, 0, 0);
    f_req = 2'b00;
    tick(); exp_f("t6_xfer", 1, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    tick(); exp_f("t6_done", 0, 0, 1, 2'b00, 2'b00, 0, 1, 0);
    f_done = 1'b0; f_grant = 1'b0;
    tick(); exp_f("t6_idle", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // Reset during XFER.
    f_req = 2'b01; f_grant = 1'b1;
    tick(); exp_f("t5_req_bus", 1, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    tick(); exp_f("t5_enable", 1, 1, 1, 2'b01, 2'b01, 0, 0, 0);
    tick(); exp_f("t5_xfer", 1, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    rst = 1'b1; f_req = 2'b00;
    tick(); exp_f("t5_reset", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    rst = 1'b0; f_done = 1'b1;
    tick(); exp_f("t5_done_ignored", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    f_done = 1'b0; f_grant = 1'b0;

    // Round-robin with both requests held: order 0, 1, 0.
    r_req = 2'b11; r_grant = 1'b1; r_cfg = 1'b1; r_done = 1'b1;
    tick(); exp_r("t2_req_bus_a", 1, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    tick(); exp_r("t2_enable_a", 1, 1, 1, 2'b01, 2'b01, 0, 0, 0);
    tick(); exp_r("t2_xfer_a", 1, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    tick(); exp_r("t2_done_a", 0, 0, 1, 2'b00, 2'b00, 0, 1, 0);
    tick(); exp_r("t2_idle_a", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    tick(); exp_r("t2_req_bus_b", 1, 1, 1, 2'b00, 2'b00, 1, 0, 0);
    tick(); exp_r("t2_enable_b", 1, 1, 1, 2'b10, 2'b10, 1, 0, 0);
    tick(); exp_r("t2_xfer_b", 1, 1, 1, 2'b00, 2'b00, 1, 0, 0);
    tick(); exp_r("t2_done_b", 0, 0, 1, 2'b00, 2'b00, 1, 1, 0);
    tick(); exp_r("t2_idle_b", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    tick(); exp_r("t2_req_bus_c", 1, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    tick(); exp_r("t2_enable_c", 1, 1, 1, 2'b01, 2'b01, 0, 0, 0);
    r_req = 2'b00;
    tick(); exp_r("t2_xfer_c", 1, 1, 1, 2'b00, 2'b00, 0, 0, 0);
    tick(); exp_r("t2_done_c", 0, 0, 1, 2'b00, 2'b00, 0, 1, 0);
    r_done = 1'b0;
    tick(); exp_r("t2_idle_c", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    exp_f("f_quiet", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
